tratador_interrupcao: RTL and testbench

TRATADOR_INTERRUPCAO -- requirements
Module: tratador_interrupcao

---
 rtl/tratador_interrupcao_if.sv | 27 ++
 rtl/tratador_interrupcao.sv | 128 ++++++++++++
 tb/tb_tratador_interrupcao.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tratador_interrupcao_if.sv
// Core-side bundle of the interrupt handler: requests and core status in,
// PC redirect and saved context out.
interface tratador_interrupcao_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  int_halt;
    logic                  int_clk;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  instr_done;
    logic                  reti;
    logic                  int_enable;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic [ADDR_WIDTH-1:0] epc;
    logic [1:0]            cause;
    logic                  in_handler;

    modport master (
        output int_halt, int_clk, pc, instr_done, reti, int_enable,
        input  pc_load, pc_target, epc, cause, in_handler
    );

    modport slave (
        input  int_halt, int_clk, pc, instr_done, reti, int_enable,
        output pc_load, pc_target, epc, cause, in_handler
    );
endinterface

// File: rtl/tratador_interrupcao.sv
// Interrupt handler: latches HALT/timer requests, vectors to the OS handler at
// an instruction boundary and resumes the interrupted process on reti.
module tratador_interrupcao #(
    parameter int                    ADDR_WIDTH   = 13,
    parameter logic [ADDR_WIDTH-1:0] HANDLER_ADDR = ADDR_WIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     reset,
    tratador_interrupcao_if.slave    bus
);
    // state | meaning: IDLE none | WAIT_BOUNDARY await commit | VECTOR jump | SERVICE handler | RETURN resume
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BOUNDARY,
        S_VECTOR,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  pend_halt;
    logic                  pend_clk;
    logic [ADDR_WIDTH-1:0] epc_q;
    logic [1:0]            cause_q;
    logic                  take_halt;
    logic                  take_clk;
    logic                  clr_cause;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_halt = 1'b0;
        take_clk  = 1'b0;
        clr_cause = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.int_enable &&
                    (pend_halt || pend_clk || bus.int_halt || bus.int_clk)) begin
                    state_nxt = S_WAIT_BOUNDARY;
                end
            end
            S_WAIT_BOUNDARY: begin
                if (bus.instr_done && bus.int_enable) begin
                    state_nxt = S_VECTOR;
                    if (pend_halt) begin
                        take_halt = 1'b1;
                    end else begin
                        take_clk = 1'b1;
                    end
                end
            end
            S_VECTOR: begin
                state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (bus.reti) begin
                    state_nxt = S_RETURN;
                    clr_cause = 1'b1;
                end
            end
            S_RETURN: begin
                if ((pend_halt || pend_clk) && bus.int_enable) begin
                    state_nxt = S_WAIT_BOUNDARY;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A request landing on the consuming edge re-arms its flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_halt <= 1'b0;
            pend_clk  <= 1'b0;
            epc_q     <= '0;
            cause_q   <= 2'b00;
        end else begin
            pend_halt <= (pend_halt & ~take_halt) | bus.int_halt;
            pend_clk  <= (pend_clk & ~take_clk) | bus.int_clk;
            if (take_halt) begin
                epc_q   <= bus.pc;
                cause_q <= 2'b10;
            end else if (take_clk) begin
                epc_q   <= bus.pc + ADDR_WIDTH'(1);
                cause_q <= 2'b01;
            end else if (clr_cause) begin
                cause_q <= 2'b00;
            end
        end
    end

    always_comb begin
        bus.pc_load    = 1'b0;
        bus.pc_target  = '0;
        bus.in_handler = 1'b0;
        bus.epc        = epc_q;
        bus.cause      = cause_q;
        case (state)
            S_VECTOR: begin
                bus.pc_load    = 1'b1;
                bus.pc_target  = HANDLER_ADDR;
                bus.in_handler = 1'b1;
            end
            S_SERVICE: begin
                bus.in_handler = 1'b1;
            end
            S_RETURN: begin
                bus.pc_load   = 1'b1;
                bus.pc_target = epc_q;
            end
            default: begin
                bus.pc_load = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_tratador_interrupcao.sv
// Bench for tratador_interrupcao: directed scenarios plus random traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_tratador_interrupcao;
    localparam int             AW      = 13;
    localparam logic [AW-1:0]  HANDLER = 13'd1;
    localparam logic [2:0] M_IDLE = 3'd0, M_WAIT = 3'd1, M_VEC = 3'd2, M_SVC = 3'd3, M_RET = 3'd4;

    typedef struct packed {
        logic [2:0]    mode;
        logic          ph;
        logic          pclk;
        logic [AW-1:0] epc;
        logic [1:0]    cause;
    } mdl_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    mdl_t m      = '0;
    logic m_valid = 1'b0;

    tratador_interrupcao_if #(.ADDR_WIDTH(AW)) bus ();

    tratador_interrupcao #(.ADDR_WIDTH(AW), .HANDLER_ADDR(HANDLER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec-level rules: pending flags, boundary vectoring, halt priority, resume.
    function automatic mdl_t step(input mdl_t c, input logic rst, input logic ih, input logic ic,
                                  input logic [AW-1:0] pcv, input logic done, input logic rt,
                                  input logic en);
        mdl_t n;
        n = c;
        if (rst) return '0;
        n.ph   = c.ph | ih;
        n.pclk = c.pclk | ic;
        case (c.mode)
            M_IDLE: if (en && (c.ph || c.pclk || ih || ic)) n.mode = M_WAIT;
            M_WAIT: if (done && en) begin
                n.mode = M_VEC;
                if (c.ph) begin
                    n.cause = 2'b10;
                    n.epc   = pcv;
                    n.ph    = ih;
                end else begin
                    n.cause = 2'b01;
                    n.epc   = AW'((32'(pcv) + 1) % (1 << AW));
                    n.pclk  = ic;
                end
            end
            M_VEC: n.mode = M_SVC;
            M_SVC: if (rt) begin
                n.mode  = M_RET;
                n.cause = 2'b00;
            end
            M_RET: n.mode = ((c.ph || c.pclk) && en) ? M_WAIT : M_IDLE;
            default: n = '0;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m, reset, bus.int_halt, bus.int_clk, bus.pc, bus.instr_done, bus.reti,
                  bus.int_enable);
        if (reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_pc_load", 32'(bus.pc_load), 32'(m.mode == M_VEC || m.mode == M_RET));
            chk("m_pc_target", 32'(bus.pc_target),
                32'((m.mode == M_VEC) ? HANDLER : (m.mode == M_RET) ? m.epc : '0));
            chk("m_in_handler", 32'(bus.in_handler), 32'(m.mode == M_VEC || m.mode == M_SVC));
            chk("m_epc", 32'(bus.epc), 32'(m.epc));
            chk("m_cause", 32'(bus.cause), 32'(m.cause));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.int_halt   = 1'b0;
        bus.int_clk    = 1'b0;
        bus.instr_done = 1'b0;
        bus.reti       = 1'b0;
    endtask

    task automatic enter_timer(input logic [AW-1:0] pcv);
        bus.pc      = pcv;
        bus.int_clk = 1'b1;
        tick();
        bus.int_clk    = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
    endtask

    task automatic finish_handler();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        bus.pc         = '0;
        bus.int_enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_cause", 32'(bus.cause), 32'd0);
        chk("rst_epc", 32'(bus.epc), 32'd0);

        // timer path
        enter_timer(13'h0040);
        chk("tmr_load", 32'(bus.pc_load), 32'd1);
        chk("tmr_target", 32'(bus.pc_target), 32'(HANDLER));
        chk("tmr_cause", 32'(bus.cause), 32'd1);
        chk("tmr_epc", 32'(bus.epc), 32'h0041);
        tick();
        chk("tmr_svc_load", 32'(bus.pc_load), 32'd0);
        chk("tmr_svc_inh", 32'(bus.in_handler), 32'd1);
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        chk("tmr_ret_load", 32'(bus.pc_load), 32'd1);
        chk("tmr_ret_target", 32'(bus.pc_target), 32'h0041);
        chk("tmr_ret_inh", 32'(bus.in_handler), 32'd0);
        chk("tmr_ret_cause", 32'(bus.cause), 32'd0);
        tick();

        // simultaneous halt + timer
        bus.pc       = 13'h0100;
        bus.int_halt = 1'b1;
        bus.int_clk  = 1'b1;
        tick();
        quiet();
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("pri_cause", 32'(bus.cause), 32'd2);
        chk("pri_epc", 32'(bus.epc), 32'h0100);
        tick();
        bus.reti = 1'b1;
        tick();
        bus.reti       = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        tick();
        bus.instr_done = 1'b0;
        chk("pri2_load", 32'(bus.pc_load), 32'd1);
        chk("pri2_cause", 32'(bus.cause), 32'd1);
        chk("pri2_epc", 32'(bus.epc), 32'h0101);
        tick();
        finish_handler();

        // masking
        bus.int_enable = 1'b0;
        bus.pc         = 13'h0200;
        bus.int_clk    = 1'b1;
        bus.instr_done = 1'b1;
        tick();
        bus.int_clk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("mask_no_load", 32'(bus.pc_load), 32'd0);
            tick();
        end
        bus.int_enable = 1'b1;
        tick();
        tick();
        bus.instr_done = 1'b0;
        chk("mask_load", 32'(bus.pc_load), 32'd1);
        chk("mask_epc", 32'(bus.epc), 32'h0201);
        tick();
        finish_handler();

        // nesting
        enter_timer(13'h0300);
        tick();
        bus.int_clk = 1'b1;
        tick();
        bus.int_clk    = 1'b0;
        bus.instr_done = 1'b1;
        bus.pc         = 13'h0310;
        for (int i = 0; i < 4; i++) begin
            chk("nest_no_load", 32'(bus.pc_load), 32'd0);
            tick();
        end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        chk("nest_ret_target", 32'(bus.pc_target), 32'h0301);
        tick();
        tick();
        bus.instr_done = 1'b0;
        chk("nest_load", 32'(bus.pc_load), 32'd1);
        chk("nest_epc", 32'(bus.epc), 32'h0311);
        tick();
        finish_handler();

        // wrap
        enter_timer(13'h1FFF);
        chk("wrap_epc", 32'(bus.epc), 32'h0000);
        tick();
        finish_handler();

        // reset mid-SERVICE
        enter_timer(13'h0444);
        tick();
        bus.int_halt = 1'b1;
        tick();
        bus.int_halt = 1'b0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsvc_load", 32'(bus.pc_load), 32'd0);
        chk("rsvc_inh", 32'(bus.in_handler), 32'd0);
        chk("rsvc_epc", 32'(bus.epc), 32'd0);
        chk("rsvc_cause", 32'(bus.cause), 32'd0);
        bus.reti       = 1'b1;
        bus.instr_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rsvc_no_load", 32'(bus.pc_load), 32'd0);
        end
        quiet();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.int_halt   = ($urandom_range(0, 15) == 0);
            bus.int_clk    = ($urandom_range(0, 7) == 0);
            bus.instr_done = ($urandom_range(0, 1) == 0);
            bus.reti       = ($urandom_range(0, 5) == 0);
            bus.int_enable = ($urandom_range(0, 7) != 0);
            bus.pc         = AW'($urandom);
            tick();
        end
        reset = 1'b0;
        quiet();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
